uart_rx_fifo_engine: RTL and testbench

- Parametrised UART receive path: baud/oversample tick generation, start-bit validation, 5–8 bit deserialisation, parity/stop/break checks, receive FIFO, trigger level and character-timeout indication.
- Sits between the rxd pin and the UART register block.
- Successor to the fixed receive shifter: adds a depth-parametrised FIFO, 16x/13x oversampling from a single clock, overrun and timeout reporting.

---
 rtl/uart_rx_fifo_engine.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_engine.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_engine
// Description : UART receive path. Oversample tick generation (16x/13x),
//               start-bit validation, 5-8 bit deserialisation, parity, stop
//               and break checks, show-ahead receive FIFO, trigger level,
//               overrun and character-timeout indication.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo_engine #(
    parameter int FIFO_DEPTH   = 16,
    parameter int DIV_WIDTH    = 16,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                            apb_clk_in,
    input  logic                            apb_rstn_in,
    input  logic [DIV_WIDTH-1:0]            divisor_in,
    input  logic                            osm_sel_in,
    input  logic [1:0]                      wls_in,
    input  logic                            pen_in,
    input  logic                            eps_in,
    input  logic                            sp_in,
    input  logic                            fifoen_in,
    input  logic [1:0]                      rxfifotl_in,
    input  logic                            rxclr_in,
    input  logic                            serial_in,
    input  logic                            rd_en_in,
    input  logic                            lsr_rd_in,
    output logic [7:0]                      rdata_out,
    output logic                            pe_out,
    output logic                            fe_out,
    output logic                            bi_out,
    output logic                            dr_out,
    output logic                            oe_out,
    output logic [$clog2(FIFO_DEPTH):0]     level_out,
    output logic                            trig_out,
    output logic                            timeout_out
);

    localparam int c_AW   = $clog2(FIFO_DEPTH);
    localparam int c_TO_W = $clog2(TIMEOUT_BITS + 1);

    localparam logic [c_AW:0]     c_DEPTH    = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_BITS);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_START    = 3'd1;
    localparam logic [2:0] c_ST_DATA     = 3'd2;
    localparam logic [2:0] c_ST_PARITY   = 3'd3;
    localparam logic [2:0] c_ST_STOP     = 3'd4;
    localparam logic [2:0] c_ST_BRK_WAIT = 3'd5;

    // ------------------------------------------------------------------
    // Line synchroniser and arming
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic [1:0] r_init;
    logic       r_armed;
    logic       w_rx;

    assign w_rx = r_sync[1];

    // Two-flop synchroniser; the line is only trusted for start detection
    // once a genuine high has passed through it after reset, so a frame
    // already in flight at reset release is ignored.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_sync  <= 2'b11;
            r_init  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], serial_in};
            r_init  <= {r_init[0], 1'b1};
            r_armed <= r_armed | (r_init[1] & w_rx);
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [DIV_WIDTH-1:0] w_div_last;
    logic                 w_tick;

    assign w_div_last = (divisor_in == '0) ? '0 : divisor_in - DIV_WIDTH'(1);
    // Compare with >= so a divisor reduced below the running count wraps at once.
    assign w_tick     = (r_div_cnt >= w_div_last);

    // Free-running divisor counter producing a one-clock tick at wrap.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [3:0] r_os_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par_s;
    logic       r_any_one;
    logic       r_push_pend;
    logic [7:0] r_push_data;
    logic       r_push_pe;
    logic       r_push_fe;
    logic       r_push_bi;

    logic [3:0] w_n_last;
    logic [3:0] w_mid_last;
    logic [2:0] w_last_bit;
    logic       w_bit_end;
    logic       w_exp_par;
    logic       w_pe;
    logic       w_bi;

    assign w_n_last   = osm_sel_in ? 4'd12 : 4'd15;
    assign w_mid_last = osm_sel_in ? 4'd5  : 4'd7;
    assign w_last_bit = 3'd4 + {1'b0, wls_in};
    assign w_bit_end  = w_tick && (r_os_cnt == w_n_last);
    // Unused upper data bits are cleared at start, so they do not disturb the XOR.
    assign w_exp_par  = sp_in ? ~eps_in : (eps_in ? ^r_shift : ~(^r_shift));
    assign w_pe       = pen_in & (r_par_s != w_exp_par);
    assign w_bi       = ~r_any_one & ~w_rx;

    // Frame sequencing: start validation, bit sampling, stop/break handling.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_state     <= c_ST_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_s     <= 1'b0;
            r_any_one   <= 1'b0;
            r_push_pend <= 1'b0;
            r_push_data <= '0;
            r_push_pe   <= 1'b0;
            r_push_fe   <= 1'b0;
            r_push_bi   <= 1'b0;
        end else begin
            r_push_pend <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_tick && !w_rx && r_armed) begin
                        r_state   <= c_ST_START;
                        r_os_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_shift   <= '0;
                        r_par_s   <= 1'b0;
                        r_any_one <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        if (r_os_cnt == w_mid_last) begin
                            r_os_cnt <= '0;
                            r_state  <= w_rx ? c_ST_IDLE : c_ST_DATA;
                        end else begin
                            r_os_cnt <= r_os_cnt + 4'd1;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_os_cnt           <= '0;
                        r_shift[r_bit_cnt] <= w_rx;
                        r_any_one          <= r_any_one | w_rx;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state <= pen_in ? c_ST_PARITY : c_ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_os_cnt  <= '0;
                        r_par_s   <= w_rx;
                        r_any_one <= r_any_one | w_rx;
                        r_state   <= c_ST_STOP;
                    end else if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_os_cnt    <= '0;
                        r_push_pend <= 1'b1;
                        r_push_data <= w_bi ? 8'h00 : r_shift;
                        r_push_pe   <= w_pe;
                        r_push_fe   <= ~w_rx;
                        r_push_bi   <= w_bi;
                        r_state     <= w_rx ? c_ST_IDLE : c_ST_BRK_WAIT;
                    end else if (w_tick) begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                end
                c_ST_BRK_WAIT: begin
                    if (w_rx) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [10:0]     r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            r_fifoen_q;
    logic            r_oe;

    logic [c_AW:0]   w_eff_depth;
    logic            w_flush;
    logic            w_full;
    logic            w_pop;
    logic            w_push;
    logic            w_ovr;
    logic [10:0]     w_head;
    logic [c_AW:0]   w_trig_lvl;

    assign w_eff_depth = fifoen_in ? c_DEPTH : (c_AW + 1)'(1);
    assign w_flush     = rxclr_in | (fifoen_in != r_fifoen_q);
    assign w_full      = (r_count >= w_eff_depth);
    assign w_pop       = rd_en_in & (r_count != '0) & ~w_flush;
    // A same-cycle pop frees the slot before the push is considered.
    assign w_push      = r_push_pend & ~w_flush & (~w_full | w_pop);
    assign w_ovr       = r_push_pend & ~w_flush & w_full & ~w_pop;
    assign w_head      = r_mem[r_rd_ptr];

    // FIFO storage write port; contents need no reset behind the count.
    always_ff @(posedge apb_clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_push_bi, r_push_fe, r_push_pe, r_push_data};
        end
    end

    // Pointer and occupancy bookkeeping, with flush on rxclr or fifoen change.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifoen_q <= 1'b0;
        end else begin
            r_fifoen_q <= fifoen_in;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + (c_AW + 1)'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - (c_AW + 1)'(1);
                end
            end
        end
    end

    // Sticky overrun; a new overrun beats a same-cycle status read.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_oe <= 1'b0;
        end else if (w_ovr) begin
            r_oe <= 1'b1;
        end else if (lsr_rd_in) begin
            r_oe <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Character timeout
    // ------------------------------------------------------------------
    logic [3:0]        r_to_tick;
    logic [c_TO_W-1:0] r_to_bits;
    logic              r_timeout;
    logic              w_to_event;

    assign w_to_event = r_push_pend | w_pop | w_flush;

    // Count idle bit-times while data waits in the FIFO and the line is quiet.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_to_tick <= '0;
            r_to_bits <= '0;
        end else if (w_to_event || (r_count == '0)) begin
            r_to_tick <= '0;
            r_to_bits <= '0;
        end else if (w_tick && (r_state == c_ST_IDLE) && !r_timeout) begin
            if (r_to_tick == w_n_last) begin
                r_to_tick <= '0;
                r_to_bits <= r_to_bits + c_TO_W'(1);
            end else begin
                r_to_tick <= r_to_tick + 4'd1;
            end
        end
    end

    // Timeout flag holds until the FIFO sees activity or a flush.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_timeout <= 1'b0;
        end else if (w_to_event) begin
            r_timeout <= 1'b0;
        end else if (r_to_bits == c_TO_LIMIT) begin
            r_timeout <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_trig_lvl = (c_AW + 1)'(1);
        case (rxfifotl_in)
            2'b00:   w_trig_lvl = (c_AW + 1)'(1);
            2'b01:   w_trig_lvl = c_DEPTH >> 2;
            2'b10:   w_trig_lvl = c_DEPTH >> 1;
            default: w_trig_lvl = c_DEPTH - (c_AW + 1)'(2);
        endcase
    end

    assign dr_out      = (r_count != '0);
    assign rdata_out   = dr_out ? w_head[7:0] : 8'h00;
    assign pe_out      = dr_out & w_head[8];
    assign fe_out      = dr_out & w_head[9];
    assign bi_out      = dr_out & w_head[10];
    assign oe_out      = r_oe;
    assign level_out   = r_count;
    assign trig_out    = dr_out & (r_count >= w_trig_lvl);
    assign timeout_out = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo_engine
// Description : Directed self-checking bench for uart_rx_fifo_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo_engine;

    logic        clk;
    logic        rst_n;
    logic [15:0] divisor;
    logic        osm_sel;
    logic [1:0]  wls;
    logic        pen;
    logic        eps;
    logic        sp;
    logic        fifoen;
    logic [1:0]  rxfifotl;
    logic        rxclr;
    logic        serial_in;
    logic        rd_en;
    logic        lsr_rd;
    logic [7:0]  rdata;
    logic        pe;
    logic        fe;
    logic        bi;
    logic        dr;
    logic        oe;
    logic [4:0]  level;
    logic        trig;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fifo_engine #(
        .FIFO_DEPTH  (16),
        .DIV_WIDTH   (16),
        .TIMEOUT_BITS(40)
    ) dut (
        .apb_clk_in  (clk),
        .apb_rstn_in (rst_n),
        .divisor_in  (divisor),
        .osm_sel_in  (osm_sel),
        .wls_in      (wls),
        .pen_in      (pen),
        .eps_in      (eps),
        .sp_in       (sp),
        .fifoen_in   (fifoen),
        .rxfifotl_in (rxfifotl),
        .rxclr_in    (rxclr),
        .serial_in   (serial_in),
        .rd_en_in    (rd_en),
        .lsr_rd_in   (lsr_rd),
        .rdata_out   (rdata),
        .pe_out      (pe),
        .fe_out      (fe),
        .bi_out      (bi),
        .dr_out      (dr),
        .oe_out      (oe),
        .level_out   (level),
        .trig_out    (trig),
        .timeout_out (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; rd_at selects the cycle index (from the start edge)
    // whose following clock edge sees rd_en high, or -1 for no read.
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                              input bit par_bit, input int n_os, input int div,
                              input int rd_at);
        logic [11:0] bits;
        int          nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nbits; i++) bits[1 + i] = data[i];
        nb = 1 + nbits;
        if (par_en) begin
            bits[nb] = par_bit;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        for (int c = 0; c < nb * n_os * div; c++) begin
            @(posedge clk);
            #1;
            serial_in = bits[c / (n_os * div)];
            rd_en     = (c == rd_at);
        end
        @(posedge clk);
        #1;
        serial_in = 1'b1;
        rd_en     = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        idle(1);
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        divisor   = 16'd1;
        osm_sel   = 1'b0;
        wls       = 2'b11;
        pen       = 1'b0;
        eps       = 1'b0;
        sp        = 1'b0;
        fifoen    = 1'b1;
        rxfifotl  = 2'b00;
        rxclr     = 1'b0;
        serial_in = 1'b1;
        rd_en     = 1'b0;
        lsr_rd    = 1'b0;
        idle(3);
        check("reset_dr", dr, 0);
        check("reset_level", level, 0);
        rst_n = 1'b1;
        idle(5);
        check("reset_oe", oe, 0);
        check("reset_trig", trig, 0);
        check("reset_timeout", timeout, 0);
        check("reset_rdata", rdata, 0);

        // Clean 8N1 frame
        send_frame(8'hA5, 8, 0, 0, 16, 1, -1);
        idle(2);
        check("8n1_rdata", rdata, 8'hA5);
        check("8n1_dr", dr, 1);
        check("8n1_flags", {pe, fe, bi}, 3'b000);
        check("8n1_level", level, 1);
        pop();
        check("8n1_pop_dr", dr, 0);

        // 7E1 with wrong parity, then stick parity (expected 1)
        wls = 2'b10; pen = 1'b1; eps = 1'b1;
        send_frame(8'h41, 7, 1, 1, 16, 1, -1);
        idle(2);
        check("7e1_rdata", rdata, 8'h41);
        check("7e1_pe", pe, 1);
        check("7e1_fe", fe, 0);
        pop();
        sp = 1'b1; eps = 1'b0;
        send_frame(8'h41, 7, 1, 1, 16, 1, -1);
        idle(2);
        check("stick_rdata", rdata, 8'h41);
        check("stick_pe", pe, 0);
        pop();
        sp = 1'b0; wls = 2'b11; pen = 1'b0;
        idle(5);

        // Break: line low for two frame times
        serial_in = 1'b0;
        idle(320);
        serial_in = 1'b1;
        idle(50);
        check("brk_level", level, 1);
        check("brk_rdata", rdata, 8'h00);
        check("brk_flags", {bi, fe}, 2'b11);
        idle(300);
        check("brk_single", level, 1);
        pop();

        // Short low glitch is rejected as a false start
        serial_in = 1'b0;
        idle(4);
        serial_in = 1'b1;
        idle(200);
        check("glitch_level", level, 0);

        // 13x oversampling with divisor 3
        osm_sel = 1'b1; divisor = 16'd3;
        idle(10);
        send_frame(8'h3C, 8, 0, 0, 13, 3, -1);
        idle(5);
        check("13x_rdata", rdata, 8'h3C);
        check("13x_fe", fe, 0);
        pop();
        osm_sel = 1'b0; divisor = 16'd1;
        idle(10);

        // Overrun: 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i), 8, 0, 0, 16, 1, -1);
        idle(5);
        check("ovr_level", level, 16);
        check("ovr_oe", oe, 1);
        lsr_rd = 1'b1;
        idle(1);
        lsr_rd = 1'b0;
        check("ovr_oe_clear", oe, 0);
        // Pop lands on the same edge as the push of this frame
        send_frame(8'h55, 8, 0, 0, 16, 1, 155);
        idle(5);
        check("fullrw_level", level, 16);
        check("fullrw_oe", oe, 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_%0d", i), rdata, (i < 15) ? 32'(i + 1) : 32'h55);
            pop();
        end
        check("drain_dr", dr, 0);

        // Character timeout after 40 idle bit-times
        send_frame(8'h77, 8, 0, 0, 16, 1, -1);
        idle(600);
        check("to_early", timeout, 0);
        idle(60);
        check("to_set", timeout, 1);
        pop();
        check("to_clear", timeout, 0);

        // Trigger at D/2 then flush
        rxfifotl = 2'b10;
        for (int i = 0; i < 7; i++) send_frame(8'(8'hC0 + i), 8, 0, 0, 16, 1, -1);
        idle(2);
        check("trig_below", trig, 0);
        send_frame(8'hC7, 8, 0, 0, 16, 1, -1);
        idle(2);
        check("trig_level", level, 8);
        check("trig_at", trig, 1);
        rxclr = 1'b1;
        idle(1);
        rxclr = 1'b0;
        check("clr_dr", dr, 0);
        check("clr_level", level, 0);
        check("clr_trig", trig, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
